// File: rtl/uart_rx_8n1_if.sv
// Serial-side bundle of the 8N1 receiver: the RX line in, recovered byte and strobes out.
// The receiver uses the slave modport; the line driver / byte consumer uses master.
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx,
        input  data,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a baud countdown,
// one-cycle data_valid / frame_error strobes and a busy flag.
module uart_rx_8n1 #(
    parameter int clock_frequency = 12000000,
    parameter int uart_baud_rate  = 9600
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_8n1_if.slave bus
);

    localparam int CLKS_PER_BIT = clock_frequency / uart_baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // The counter counts down to zero, so a wait of N cycles reloads N-1.
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_data_valid;
    logic             r_frame_error;
    logic             r_busy;

    logic             w_baud_done;

    assign w_baud_done     = (r_baud_cnt == '0);

    assign bus.data        = r_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values,
    // which keeps the two synchronizer stages as two distinct registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rx_meta     <= 1'b1;
            r_rx_s        <= 1'b1;
            r_baud_cnt    <= '0;
            r_bit_idx     <= 3'd0;
            r_data        <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_meta     <= bus.rx;
            r_rx_s        <= r_rx_meta;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;

            // NOTE: r_shift is deliberately left out of reset: every bit is rewritten
            // in DATA before it can reach r_data.
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (!r_rx_s) begin
                        r_baud_cnt <= HALF_RELOAD;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (!w_baud_done) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else if (r_rx_s) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud_cnt <= BIT_RELOAD;
                        r_bit_idx  <= 3'd0;
                        r_state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (!w_baud_done) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_baud_cnt         <= BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                    if (!w_baud_done) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else if (r_rx_s) begin
                        r_data       <= r_shift;
                        r_data_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_frame_error <= 1'b1;
                        r_state       <= S_WAIT_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: a 16-clocks-per-bit instance for directed and random
// frames, plus a default-parameter instance for real-baud reception and rate tolerance.
module tb_uart_rx_8n1;

    localparam int C_S = 16;
    localparam int C_D = 1250;

    logic clk = 1'b0;
    logic rst_n_s;
    logic rst_n_d;

    always #5 clk = ~clk;

    uart_rx_8n1_if if_s ();
    uart_rx_8n1_if if_d ();

    uart_rx_8n1 #(
        .clock_frequency(16),
        .uart_baud_rate (1)
    ) dut_s (
        .clk  (clk),
        .rst_n(rst_n_s),
        .bus  (if_s.slave)
    );

    uart_rx_8n1 dut_d (
        .clk  (clk),
        .rst_n(rst_n_d),
        .bus  (if_d.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and output monitors (sampled on the falling edge).
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  got_s[$];
    logic [7:0]  got_d[$];
    int          vs_cnt = 0, fes_cnt = 0, s_overlap = 0, s_double = 0;
    int          vd_cnt = 0, fed_cnt = 0, d_overlap = 0;
    int unsigned last_vs_cyc = 0, last_vd_cyc = 0;
    logic        prev_strobe_s = 1'b0;
    logic        busy_prev_s = 1'b0, busy_at_valid_s = 1'b1, busy_before_valid_s = 1'b0;

    always @(negedge clk) begin
        if (rst_n_s) begin
            if (if_s.data_valid) begin
                vs_cnt              <= vs_cnt + 1;
                got_s.push_back(if_s.data);
                last_vs_cyc         <= cyc;
                busy_at_valid_s     <= if_s.busy;
                busy_before_valid_s <= busy_prev_s;
            end
            if (if_s.frame_error) fes_cnt <= fes_cnt + 1;
            if (if_s.data_valid && if_s.frame_error) s_overlap <= s_overlap + 1;
            if ((if_s.data_valid || if_s.frame_error) && prev_strobe_s) s_double <= s_double + 1;
        end
        prev_strobe_s <= if_s.data_valid | if_s.frame_error;
        busy_prev_s   <= if_s.busy;
    end

    always @(negedge clk) begin
        if (rst_n_d) begin
            if (if_d.data_valid) begin
                vd_cnt      <= vd_cnt + 1;
                got_d.push_back(if_d.data);
                last_vd_cyc <= cyc;
            end
            if (if_d.frame_error) fed_cnt <= fed_cnt + 1;
            if (if_d.data_valid && if_d.frame_error) d_overlap <= d_overlap + 1;
        end
    end

    function automatic int pop_s();
        if (got_s.size() == 0) return -1;
        return int'(got_s.pop_front());
    endfunction

    function automatic int pop_d();
        if (got_d.size() == 0) return -1;
        return int'(got_d.pop_front());
    endfunction

    // Line driver: holds a level for n cycles; callers stay aligned to posedge + 1.
    task automatic drive(input bit dflt, input logic v, input int n);
        if (dflt) if_d.rx = v;
        else      if_s.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit dflt, input logic [7:0] b, input logic stop_bit,
                        input int len, output int unsigned start_cyc);
        start_cyc = cyc;
        drive(dflt, 1'b0, len);
        for (int i = 0; i < 8; i++) drive(dflt, b[i], len);
        drive(dflt, stop_bit, len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int          base_v, base_fe, lat;
        logic [7:0]  last_good;
        logic [7:0]  b;
        logic        bad;

        rst_n_s = 1'b0;
        rst_n_d = 1'b0;
        if_s.rx = 1'b1;
        if_d.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data",  if_s.data, 8'h00);
        check("rst_valid", if_s.data_valid, 0);
        check("rst_fe",    if_s.frame_error, 0);
        check("rst_busy",  if_s.busy, 0);
        rst_n_s = 1'b1;
        rst_n_d = 1'b1;
        drive(0, 1'b1, 10);

        // Single byte with latency and busy-fall timing.
        send(0, 8'hA5, 1'b1, C_S, t0);
        drive(0, 1'b1, 8);
        check("a5_count", vs_cnt, 1);
        check("a5_data", pop_s(), 8'hA5);
        lat = int'(last_vs_cyc - t0);
        check("a5_latency_window", (lat >= 2 + C_S/2 + 9*C_S - 1) && (lat <= 2 + C_S/2 + 9*C_S + 1), 1);
        check("a5_busy_at_valid", busy_at_valid_s, 0);
        check("a5_busy_before_valid", busy_before_valid_s, 1);

        // Back-to-back frames with no idle gap.
        base_v = vs_cnt; base_fe = fes_cnt;
        send(0, 8'h00, 1'b1, C_S, t0);
        send(0, 8'hFF, 1'b1, C_S, t0);
        drive(0, 1'b1, 8);
        check("b2b_count", vs_cnt - base_v, 2);
        check("b2b_first", pop_s(), 8'h00);
        check("b2b_second", pop_s(), 8'hFF);
        check("b2b_no_fe", fes_cnt - base_fe, 0);

        // Short low glitch shorter than half a bit.
        base_v = vs_cnt; base_fe = fes_cnt;
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 30);
        check("glitch_no_valid", vs_cnt - base_v, 0);
        check("glitch_no_fe", fes_cnt - base_fe, 0);
        check("glitch_data_kept", if_s.data, 8'hFF);
        check("glitch_busy", if_s.busy, 0);

        // Framing error followed by a long break.
        base_v = vs_cnt; base_fe = fes_cnt;
        send(0, 8'h3C, 1'b0, C_S, t0);
        drive(0, 1'b0, 100);
        check("fe_busy_in_break", if_s.busy, 1);
        check("fe_one_pulse", fes_cnt - base_fe, 1);
        check("fe_no_valid", vs_cnt - base_v, 0);
        check("fe_data_kept", if_s.data, 8'hFF);
        drive(0, 1'b1, 6);
        check("fe_busy_released", if_s.busy, 0);
        send(0, 8'h81, 1'b1, C_S, t0);
        drive(0, 1'b1, 8);
        check("fe_next_data", pop_s(), 8'h81);
        check("fe_still_one", fes_cnt - base_fe, 1);

        // Reset during data bit 3 of 0x55.
        base_v = vs_cnt;
        b = 8'h55;
        drive(0, 1'b0, C_S);
        for (int i = 0; i < 3; i++) drive(0, b[i], C_S);
        drive(0, b[3], 8);
        rst_n_s = 1'b0;
        if_s.rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_data",  if_s.data, 8'h00);
        check("mid_rst_valid", if_s.data_valid, 0);
        check("mid_rst_fe",    if_s.frame_error, 0);
        check("mid_rst_busy",  if_s.busy, 0);
        rst_n_s = 1'b1;
        drive(0, 1'b1, 20);
        check("mid_rst_no_strobe", vs_cnt - base_v, 0);
        send(0, 8'h7E, 1'b1, C_S, t0);
        drive(0, 1'b1, 8);
        check("mid_rst_next", pop_s(), 8'h7E);
        last_good = 8'h7E;

        // Random frames: good bytes must arrive in order, bad stop bits give one error each.
        for (int k = 0; k < 24; k++) begin
            b       = 8'($urandom);
            bad     = ($urandom_range(0, 5) == 0);
            base_v  = vs_cnt;
            base_fe = fes_cnt;
            send(0, b, ~bad, C_S, t0);
            if (bad) begin
                drive(0, 1'b0, $urandom_range(0, 40));
                drive(0, 1'b1, 3 + $urandom_range(0, 12));
                check("rnd_fe", fes_cnt - base_fe, 1);
                check("rnd_fe_no_valid", vs_cnt - base_v, 0);
                check("rnd_fe_data_kept", if_s.data, last_good);
            end else begin
                drive(0, 1'b1, $urandom_range(0, 12));
                check("rnd_count", vs_cnt - base_v, 1);
                check("rnd_data", pop_s(), b);
                check("rnd_no_fe", fes_cnt - base_fe, 0);
                last_good = b;
            end
        end
        drive(0, 1'b1, 8);
        check("s_overlap", s_overlap, 0);
        check("s_double", s_double, 0);

        // Default parameters: 12 MHz / 9600 baud, exact rate then 3% slow sender.
        send(1, 8'h50, 1'b1, C_D, t0);
        drive(1, 1'b1, 20);
        check("dflt_data_P", pop_d(), 8'h50);
        lat = int'(last_vd_cyc - t0);
        check("dflt_latency_window", (lat >= 2 + C_D/2 + 9*C_D - 1) && (lat <= 2 + C_D/2 + 9*C_D + 1), 1);
        send(1, 8'hC3, 1'b1, 1290, t0);
        drive(1, 1'b1, 20);
        check("dflt_slow_data", pop_d(), 8'hC3);
        check("dflt_count", vd_cnt, 2);
        check("dflt_no_fe", fed_cnt, 0);
        check("dflt_overlap", d_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver for the perceptron host link: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly downstream of the board RX pin (FTDI_RX) and upstream of the perceptron command/weight loader inside perceptron_top.
- Recovers bytes by mid-bit sampling from a baud-tick counter.
- Emits each byte with a one-cycle valid strobe, and flags framing errors.

Parameters:
- clock_frequency, 12000000, system clock frequency in Hz.
- uart_baud_rate, 9600, line baud rate in bits/s.
- CLKS_PER_BIT, clock_frequency/uart_baud_rate (1250 at defaults), derived localparam; counter width = clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  last correctly received byte; holds until the next good byte.
- data_valid  output  1  one-cycle strobe; data is new and stable this cycle.
- frame_error  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high while a frame is in progress or while waiting for line idle.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, both synchronizer flops=1, bit counter=0, baud counter=0.
  - data=8'h00, data_valid=0, frame_error=0, busy=0.
  - Reset mid-frame abandons the frame; no strobe is produced for it.
- Input synchronizer: 2-flop chain on rx (reset value 1). All decisions use the second flop (rx_s), so there is 2 cycles of input latency.
- IDLE:
  - busy=0.
  - When rx_s==0: load baud counter, go to START.
- START:
  - Wait CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
  - If rx_s==1, the start was a glitch: go to IDLE with no strobe.
  - Else reload the counter and go to DATA with bit index=0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register position bit index, LSB first.
  - After index 7 is sampled, reload and go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If 1: data<=shift register and data_valid=1 for exactly one cycle. Next state IDLE (no wait for the end of the stop bit), so back-to-back frames are accepted.
  - If 0: frame_error=1 for one cycle, data unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - busy=1.
  - Stay until rx_s==1, then go to IDLE. This covers a break condition: a held-low line yields only one frame_error, not repeated frames.
- busy=1 in START, DATA, STOP and WAIT_IDLE.
- data_valid and frame_error are mutually exclusive and never asserted in consecutive cycles for one frame.
- Latency: the strobe occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling start edge reaches rx (±1 cycle).
- Tolerance: sampling at mid-bit tolerates ±4% baud mismatch over 10 bits. No oversampling or majority vote.
- Counter is sized for CLKS_PER_BIT ≥ 4; smaller values are unsupported.
- No back-pressure: the consumer must take data on data_valid; a later byte overwrites it.

Test Plan:
- Single byte: CLKS_PER_BIT=16 (clock_frequency=16, uart_baud_rate=1) for sim. Drive 0xA5 as 8N1 → data==8'hA5, data_valid high for exactly 1 cycle, 2+8+144 (±1) cycles after the start edge; busy falls the same cycle.
- Back-to-back: send 0x00 then 0xFF with no idle gap → two data_valid pulses, data 8'h00 then 8'hFF, frame_error never high.
- Glitch rejection: pull rx low for 4 cycles (< CLKS_PER_BIT/2), then high → returns to IDLE, no data_valid, no frame_error, data unchanged.
- Framing error: send 0x3C with the stop bit low and hold rx low for 100 cycles, then release → exactly one frame_error pulse, no data_valid, data keeps its previous value, busy stays high until rx_s returns to 1. A following valid 0x81 frame is received correctly.
- Reset mid-frame: assert rst_n low during data bit 3 of 0x55, release, then send 0x7E → no strobe for the aborted frame, and all outputs equal their reset values during reset. The next data_valid carries 8'h7E.
- Default parameters: 12 MHz / 9600 baud, send "P" (0x50) → data==8'h50 received; check CLKS_PER_BIT==1250 sampling points at mid-bit.
